// File: rtl/pheap_level_mem.sv
// One level of the pipelined heap: 2**LEVEL entries {value, ptr, active} with a swept init.
// Optional write-through forwarding on same-address read/write: define PHEAP_LEVEL_BYPASS_EN.
module pheap_level_mem #(
  parameter int VALUE_W = 32,
  parameter int LEVELS  = 4,
  parameter int LEVEL   = 0,
  localparam int ADDR_W  = (LEVEL == 0) ? 1 : LEVEL,
  localparam int ENTRY_W = VALUE_W + LEVELS + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               ready,
  input  logic               rd_en,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [ENTRY_W-1:0] rd_data,
  output logic               rd_valid,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [ENTRY_W-1:0] wr_data,
  output logic [ADDR_W:0]    active_cnt
);

  localparam int DEPTH = 2 ** LEVEL;
  localparam logic [ENTRY_W-1:0] EMPTY = {{VALUE_W{1'b0}}, {LEVELS{1'b1}}, 1'b0};
  localparam logic [ADDR_W-1:0]  LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]    CNT_MAX = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {INIT, RUN} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  sweep_ptr;
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]   act_q;
  logic [ADDR_W-1:0]  ra, wa;
  logic               run, wr_go, old_act, new_act, fwd;

  // A single-slot level ignores the address bits entirely.
  assign ra = (LEVEL == 0) ? '0 : rd_addr;
  assign wa = (LEVEL == 0) ? '0 : wr_addr;

  assign run     = (state_q == RUN);
  assign ready   = run;
  assign wr_go   = run && wr_en;
  assign old_act = act_q[wa];
  assign new_act = wr_data[0];

`ifdef PHEAP_LEVEL_BYPASS_EN
  assign fwd = wr_en && (ra == wa);
`else
  assign fwd = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= INIT;
      sweep_ptr <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == INIT)
        sweep_ptr <= sweep_ptr + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == INIT && sweep_ptr == LAST)
      state_d = RUN;
  end

  // Storage itself is not reset; the INIT sweep gives it defined contents.
  always_ff @(posedge clk) begin
    if (state_q == INIT)
      mem[sweep_ptr] <= EMPTY;
    else if (wr_en)
      mem[wa] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= EMPTY;
    end else if (run && rd_en) begin
      rd_valid <= 1'b1;
      rd_data  <= fwd ? wr_data : mem[ra];
    end else begin
      rd_valid <= 1'b0;
    end
  end

  // The count tracks active-bit transitions only, so it always equals popcount(act_q).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q      <= '0;
      active_cnt <= '0;
    end else if (state_q == INIT) begin
      act_q      <= '0;
      active_cnt <= '0;
    end else if (wr_go) begin
      act_q[wa] <= new_act;
      if (new_act && !old_act && active_cnt != CNT_MAX)
        active_cnt <= active_cnt + 1'b1;
      else if (!new_act && old_act && active_cnt != '0)
        active_cnt <= active_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_pheap_level_mem.sv
// Bench for pheap_level_mem: a LEVEL=2 instance checked against a slot-array model every
// cycle, plus literal checks, and a LEVEL=0 instance checked with literals only.
module tb_pheap_level_mem;

  localparam int VW = 32;
  localparam int LV = 4;
  localparam int EW = VW + LV + 1;
  localparam logic [EW-1:0] EMPTY = {32'h0, 4'hF, 1'b0};

  logic          clk = 1'b0;
  logic          rst_n, rd_en, wr_en, rd_valid, ready;
  logic [1:0]    rd_addr, wr_addr;
  logic [EW-1:0] wr_data, rd_data;
  logic [2:0]    active_cnt;

  logic          z_rst_n, z_rd_en, z_wr_en, z_rd_valid, z_ready;
  logic [0:0]    z_rd_addr, z_wr_addr;
  logic [EW-1:0] z_wr_data, z_rd_data;
  logic [1:0]    z_active_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_on   = 1'b0;

  always #5 clk = ~clk;

  pheap_level_mem #(.VALUE_W(VW), .LEVELS(LV), .LEVEL(2)) dut (
    .clk(clk), .rst_n(rst_n), .ready(ready),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .active_cnt(active_cnt)
  );

  pheap_level_mem #(.VALUE_W(VW), .LEVELS(LV), .LEVEL(0)) dut0 (
    .clk(clk), .rst_n(z_rst_n), .ready(z_ready),
    .rd_en(z_rd_en), .rd_addr(z_rd_addr), .rd_data(z_rd_data), .rd_valid(z_rd_valid),
    .wr_en(z_wr_en), .wr_addr(z_wr_addr), .wr_data(z_wr_data), .active_cnt(z_active_cnt)
  );

  function automatic logic [EW-1:0] mk(input logic [31:0] v, input logic [3:0] p, input logic a);
    return {v, p, a};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Model: slot contents, remaining sweep cycles, and the last read result.
  logic [EW-1:0] m_mem [4];
  int            m_init_left;
  logic          m_valid;
  logic [EW-1:0] m_data;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) m_mem[i] = EMPTY;
      m_init_left = 4;
      m_valid     = 1'b0;
      m_data      = EMPTY;
    end else if (m_init_left > 0) begin
      m_init_left--;
      m_valid = 1'b0;
    end else begin
      m_valid = rd_en;
      if (rd_en) begin
`ifdef PHEAP_LEVEL_BYPASS_EN
        m_data = (wr_en && rd_addr == wr_addr) ? wr_data : m_mem[rd_addr];
`else
        m_data = m_mem[rd_addr];
`endif
      end
      if (wr_en) m_mem[wr_addr] = wr_data;
    end
  end

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < 4; i++) c += int'(m_mem[i][0]);
    return c;
  endfunction

  always begin
    @(posedge clk);
    #2;
    if (cmp_on) begin
      check("model ready",    64'(ready),      64'(m_init_left == 0));
      check("model rd_valid", 64'(rd_valid),   64'(m_valid));
      check("model rd_data",  64'(rd_data),    64'(m_data));
      check("model cnt",      64'(active_cnt), 64'(m_count()));
    end
  end

  task automatic applyStimulus(input logic re, input logic [1:0] ra, input logic we,
                               input logic [1:0] wa, input logic [EW-1:0] wd);
    @(negedge clk);
    rd_en = re; rd_addr = ra; wr_en = we; wr_addr = wa; wr_data = wd;
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 2'd0, 1'b0, 2'd0, '0);
  endtask

  initial begin
    logic [EW-1:0] e42, e55, coll_exp;
    e42 = mk(32'h0000_0042, 4'h3, 1'b1);
    e55 = mk(32'h55, 4'h0, 1'b1);
`ifdef PHEAP_LEVEL_BYPASS_EN
    coll_exp = e55;
`else
    coll_exp = EMPTY;
`endif
    rst_n = 1'b0; rd_en = 0; wr_en = 0; rd_addr = 0; wr_addr = 0; wr_data = '0;
    z_rst_n = 1'b0; z_rd_en = 0; z_wr_en = 0; z_rd_addr = 0; z_wr_addr = 0; z_wr_data = '0;
    repeat (2) @(posedge clk);
    #2;
    check("reset ready", 64'(ready), 64'd0);
    check("reset rd_data", 64'(rd_data), 64'(EMPTY));
    check("reset cnt", 64'(active_cnt), 64'd0);

    // Init sweep: ready rises after exactly 4 edges.
    @(negedge clk);
    rst_n  = 1'b1;
    cmp_on = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #2;
      check($sformatf("init ready edge %0d", k), 64'(ready), 64'(k == 4));
    end

    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 2'(i), 1'b0, 2'd0, '0);
      check($sformatf("swept slot %0d", i), 64'(rd_data), 64'(EMPTY));
      check("swept rd_valid", 64'(rd_valid), 64'd1);
    end
    idle();
    check("rd_valid drops", 64'(rd_valid), 64'd0);
    check("cnt after sweep", 64'(active_cnt), 64'd0);

    applyStimulus(1'b0, 2'd0, 1'b1, 2'd2, e42);
    check("cnt after write", 64'(active_cnt), 64'd1);
    applyStimulus(1'b1, 2'd2, 1'b0, 2'd0, '0);
    check("basic rd_data", 64'(rd_data), 64'(e42));
    check("basic rd_valid", 64'(rd_valid), 64'd1);

    applyStimulus(1'b1, 2'd1, 1'b1, 2'd1, e55);
    check("collision rd_data", 64'(rd_data), 64'(coll_exp));
    applyStimulus(1'b1, 2'd1, 1'b0, 2'd0, '0);
    check("post collision read", 64'(rd_data), 64'(e55));
    check("cnt after collision", 64'(active_cnt), 64'd2);

    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, 2'd0, 1'b1, 2'(i), mk(32'(i + 16), 4'(i), 1'b1));
    check("cnt all active", 64'(active_cnt), 64'd4);
    applyStimulus(1'b0, 2'd0, 1'b1, 2'd3, mk(32'h99, 4'h1, 1'b1));
    check("cnt rewrite active", 64'(active_cnt), 64'd4);
    applyStimulus(1'b0, 2'd0, 1'b1, 2'd0, mk(32'h7, 4'h2, 1'b0));
    check("cnt deactivate", 64'(active_cnt), 64'd3);
    applyStimulus(1'b1, 2'd3, 1'b0, 2'd0, '0);
    check("rewritten slot 3", 64'(rd_data), 64'(mk(32'h99, 4'h1, 1'b1)));

    // Half-cycle reset pulse, with requests held high through the whole re-sweep.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async ready", 64'(ready), 64'd0);
    check("async rd_valid", 64'(rd_valid), 64'd0);
    check("async rd_data", 64'(rd_data), 64'(EMPTY));
    check("async cnt", 64'(active_cnt), 64'd0);
    rd_en = 1'b1; rd_addr = 2'd0; wr_en = 1'b1; wr_addr = 2'd0; wr_data = e42;
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    check("resweep ready edge 1", 64'(ready), 64'd0);
    check("resweep rd_valid edge 1", 64'(rd_valid), 64'd0);
    for (int k = 2; k <= 4; k++) begin
      applyStimulus(1'b1, 2'(k - 1), 1'b1, 2'(k - 1), e42);
      check($sformatf("resweep ready edge %0d", k), 64'(ready), 64'(k == 4));
      check("resweep rd_valid", 64'(rd_valid), 64'd0);
    end
    idle();
    check("cnt after resweep", 64'(active_cnt), 64'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 2'(i), 1'b0, 2'd0, '0);
      check($sformatf("resweep slot %0d", i), 64'(rd_data), 64'(EMPTY));
    end
    idle();

    // LEVEL=0: one sweep cycle, address bits ignored.
    @(negedge clk);
    z_rst_n = 1'b1;
    #1;
    check("L0 ready before edge", 64'(z_ready), 64'd0);
    @(posedge clk);
    #2;
    check("L0 ready after 1 edge", 64'(z_ready), 64'd1);
    @(negedge clk);
    z_wr_en = 1'b1; z_wr_addr = 1'b1; z_wr_data = mk(32'h77, 4'h5, 1'b1);
    @(negedge clk);
    z_wr_en = 1'b0; z_rd_en = 1'b1; z_rd_addr = 1'b0;
    @(posedge clk);
    #2;
    check("L0 read addr0", 64'(z_rd_data), 64'(mk(32'h77, 4'h5, 1'b1)));
    check("L0 rd_valid", 64'(z_rd_valid), 64'd1);
    check("L0 cnt", 64'(z_active_cnt), 64'd1);
    @(negedge clk);
    z_rd_en = 1'b0;

    cmp_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
